// File: rtl/svm_coeff_sched.sv
// svm_coeff_sched: frame-synchronous SVM coefficient sequencer.
// Define SVMSCHED_BIAS_EN to add the config-written svbias output.
module svm_coeff_sched #(
  parameter int CWIDTH    = 9,
  parameter int WPI       = 32,
  parameter int NCOEFF    = 2048,
  parameter int ADV_PHASE = 1,
  parameter int AWIDTH    = $clog2(NCOEFF+1)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     cfg_we,
  input  logic [AWIDTH-1:0]        cfg_addr,
  input  logic signed [CWIDTH-1:0] cfg_wdata,
  input  logic                     cfg_last,
  output logic                     cfg_err,
  input  logic                     frame_start,
  input  logic                     dvi,
  input  logic [$clog2(WPI)-1:0]   wincount,
  output logic signed [CWIDTH-1:0] svcoeff_out,
  output logic                     coeff_valid,
  output logic                     frame_done,
  output logic                     busy
`ifdef SVMSCHED_BIAS_EN
  ,
  output logic signed [CWIDTH-1:0] svbias
`endif
);
  localparam int WW = $clog2(WPI);
  localparam int IW = (NCOEFF > 1) ? $clog2(NCOEFF) : 1;
  localparam logic [AWIDTH-1:0] NC = AWIDTH'(NCOEFF);
  localparam logic [AWIDTH-1:0] LASTP = AWIDTH'(NCOEFF-1);
  localparam logic [WW-1:0] ADVP = WW'(ADV_PHASE);

  typedef enum logic [2:0] {
    IDLE, READY, PRIME1, PRIME2, RUN, DONE
  } state_t;

  state_t state_q, state_d;
  logic [AWIDTH-1:0] ptr_q, ptr_d;
  logic [AWIDTH-1:0] raddr;
  logic signed [CWIDTH-1:0] coeff_q, coeff_d;
  logic signed [CWIDTH-1:0] nxt_q;
  logic done_q, done_d;
  logic err_q, err_d;
  logic act, addr_ok, cfg_ok, wr_mem, adv;
  logic signed [CWIDTH-1:0] mem [NCOEFF];

  assign act = (state_q == PRIME1) || (state_q == PRIME2) ||
               (state_q == RUN);
`ifdef SVMSCHED_BIAS_EN
  assign addr_ok = cfg_addr <= NC;
`else
  assign addr_ok = cfg_addr < NC;
`endif
  assign cfg_ok = cfg_we && addr_ok && !act;
  assign wr_mem = cfg_ok && (cfg_addr < NC);
  assign adv = dvi && (wincount == ADVP);

  // Next-state, pointer, output coefficient and pulse generation
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    coeff_d = coeff_q;
    done_d  = 1'b0;
    err_d   = cfg_we && !cfg_ok;
    raddr   = (state_q == PRIME1) ? '0 : ptr_q + AWIDTH'(1);
    unique case (state_q)
      IDLE: begin
        if (cfg_ok && cfg_last) state_d = READY;
      end
      READY, DONE: begin
        if (frame_start) begin
          state_d = PRIME1;
          ptr_d   = '0;
        end
      end
      PRIME1: state_d = PRIME2;
      PRIME2: begin
        coeff_d = nxt_q;
        state_d = RUN;
      end
      RUN: begin
        if (frame_start) begin
          state_d = PRIME1;
          ptr_d   = '0;
        end else if (adv) begin
          if (ptr_q == LASTP) begin
            coeff_d = '0;
            done_d  = 1'b1;
            state_d = DONE;
          end else begin
            coeff_d = nxt_q;
            ptr_d   = ptr_q + AWIDTH'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Control and output registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      coeff_q <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      coeff_q <= coeff_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  // Coefficient RAM; the read port keeps the prefetch one word ahead
  always_ff @(posedge clk) begin
    if (wr_mem) mem[cfg_addr[IW-1:0]] <= cfg_wdata;
    nxt_q <= (raddr < NC) ? mem[raddr[IW-1:0]] : '0;
  end

`ifdef SVMSCHED_BIAS_EN
  logic signed [CWIDTH-1:0] bias_q;

  // Bias register, only writable while idle so it is stable in a frame
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) bias_q <= '0;
    else if (cfg_ok && (cfg_addr == NC)) bias_q <= cfg_wdata;
  end

  assign svbias = bias_q;
`endif

  assign svcoeff_out = coeff_q;
  assign coeff_valid = (state_q == RUN);
  assign busy        = act;
  assign frame_done  = done_q;
  assign cfg_err     = err_q;
endmodule
